// File: rtl/rmst_arbiter.sv
// Round-robin arbiter that shares one Avalon read master between three load controllers.
// Holds one queued request per requester and issues a single burst at a time.
module rmst_arbiter #(
    parameter int unsigned XAW  = 32,
    parameter int unsigned CW   = 16,
    parameter int unsigned NREQ = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_trans_start,
    input  logic [NREQ*XAW-1:0] req_raddr,
    input  logic [NREQ*CW-1:0]  req_iolen,
    output logic [NREQ-1:0]     req_trans_done,
    output logic                rmst_trans_start,
    output logic [XAW-1:0]      rmst_raddr,
    output logic [CW-1:0]       rmst_iolen,
    input  logic                rmst_trans_done,
    output logic [1:0]          rmst_grant_id,
    output logic                rmst_busy,
    output logic                proto_err
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [XAW-1:0]  slot_addr_q [NREQ];
    logic [XAW-1:0]  slot_addr_d [NREQ];
    logic [CW-1:0]   slot_len_q  [NREQ];
    logic [CW-1:0]   slot_len_d  [NREQ];
    logic [XAW-1:0]  raddr_q, raddr_d;
    logic [CW-1:0]   iolen_q, iolen_d;
    logic [1:0]      grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] capture;
    logic [NREQ-1:0] collide;
    logic [1:0]      cand0, cand1, cand2;
    logic            pick_valid;
    logic [1:0]      pick_idx;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign capture = req_trans_start & ~pending_q;
    assign collide = req_trans_start & pending_q;

    // Scan order rr_ptr, rr_ptr+1, rr_ptr+2; later assignments take priority.
    always_comb begin
        cand0      = rr_ptr_q;
        cand1      = inc3(rr_ptr_q);
        cand2      = inc3(cand1);
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        if (pending_q[cand2]) begin
            pick_valid = 1'b1;
            pick_idx   = cand2;
        end
        if (pending_q[cand1]) begin
            pick_valid = 1'b1;
            pick_idx   = cand1;
        end
        if (pending_q[cand0]) begin
            pick_valid = 1'b1;
            pick_idx   = cand0;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | capture;
        rr_ptr_d  = rr_ptr_q;
        raddr_d   = raddr_q;
        iolen_d   = iolen_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = err_q | (|collide);
        for (int i = 0; i < NREQ; i++) begin
            slot_addr_d[i] = slot_addr_q[i];
            slot_len_d[i]  = slot_len_q[i];
            if (capture[i]) begin
                slot_addr_d[i] = req_raddr[i*XAW +: XAW];
                slot_len_d[i]  = req_iolen[i*CW +: CW];
            end
        end

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StIssue;
                    raddr_d = slot_addr_q[pick_idx];
                    iolen_d = slot_len_q[pick_idx];
                    grant_d = pick_idx;
                end
            end
            StIssue: begin
                state_d = StBusy;
            end
            StBusy: begin
                // A capture from another requester on this edge survives the clear below.
                if (rmst_trans_done) begin
                    done_d[grant_q]    = 1'b1;
                    pending_d[grant_q] = 1'b0;
                    rr_ptr_d           = inc3(grant_q);
                    state_d            = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            rr_ptr_q  <= 2'd0;
            raddr_q   <= '0;
            iolen_q   <= '0;
            grant_q   <= 2'd0;
            done_q    <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_len_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            raddr_q   <= raddr_d;
            iolen_q   <= iolen_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            for (int i = 0; i < NREQ; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_len_q[i]  <= slot_len_d[i];
            end
        end
    end

    assign req_trans_done   = done_q;
    assign rmst_trans_start = (state_q == StIssue);
    assign rmst_busy        = (state_q != StIdle);
    assign rmst_raddr       = raddr_q;
    assign rmst_iolen       = iolen_q;
    assign rmst_grant_id    = grant_q;
    assign proto_err        = err_q;

endmodule

// File: tb/tb_rmst_arbiter.sv
// Directed bench for rmst_arbiter: single burst, round-robin order, fairness,
// protocol error, stray done and reset mid-burst.
module tb_rmst_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_trans_start;
    logic [95:0] req_raddr;
    logic [47:0] req_iolen;
    logic [2:0]  req_trans_done;
    logic        rmst_trans_start;
    logic [31:0] rmst_raddr;
    logic [15:0] rmst_iolen;
    logic        rmst_trans_done;
    logic [1:0]  rmst_grant_id;
    logic        rmst_busy;
    logic        proto_err;

    int total;
    int bad;

    rmst_arbiter #(
        .XAW (32),
        .CW  (16),
        .NREQ(3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_trans_start (req_trans_start),
        .req_raddr       (req_raddr),
        .req_iolen       (req_iolen),
        .req_trans_done  (req_trans_done),
        .rmst_trans_start(rmst_trans_start),
        .rmst_raddr      (rmst_raddr),
        .rmst_iolen      (rmst_iolen),
        .rmst_trans_done (rmst_trans_done),
        .rmst_grant_id   (rmst_grant_id),
        .rmst_busy       (rmst_busy),
        .proto_err       (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] l);
        req_trans_start[i]     = 1'b1;
        req_raddr[i*32 +: 32]  = a;
        req_iolen[i*16 +: 16]  = l;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 64'(rmst_trans_start), 64'd0);
        check({tag, "_busy"},  64'(rmst_busy),        64'd0);
        check({tag, "_raddr"}, 64'(rmst_raddr),       64'd0);
        check({tag, "_iolen"}, 64'(rmst_iolen),       64'd0);
        check({tag, "_grant"}, 64'(rmst_grant_id),    64'd0);
        check({tag, "_rdone"}, 64'(req_trans_done),   64'd0);
        check({tag, "_err"},   64'(proto_err),        64'd0);
    endtask

    // Entered just after the edge that moved the arbiter into ISSUE; returns just
    // after the edge that sampled rmst_trans_done.
    task automatic serve(input string tag, input int g, input logic [31:0] a,
                         input logic [15:0] l);
        check({tag, "_start"}, 64'(rmst_trans_start), 64'd1);
        check({tag, "_grant"}, 64'(rmst_grant_id),    64'(g));
        check({tag, "_raddr"}, 64'(rmst_raddr),       64'(a));
        check({tag, "_iolen"}, 64'(rmst_iolen),       64'(l));
        check({tag, "_busy"},  64'(rmst_busy),        64'd1);
        step();
        check({tag, "_start_low"}, 64'(rmst_trans_start), 64'd0);
        check({tag, "_busy_mid"},  64'(rmst_busy),        64'd1);
        step();
        step();
        rmst_trans_done = 1'b1;
        step();
        rmst_trans_done = 1'b0;
        check({tag, "_rdone"},    64'(req_trans_done), 64'(3'b001 << g));
        check({tag, "_busy_end"}, 64'(rmst_busy),      64'd0);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        req_trans_start = '0;
        req_raddr       = '0;
        req_iolen       = '0;
        rmst_trans_done = 1'b0;
        #2;
        check_all_zero("reset");
        step();
        rst = 1'b0;

        // Single request from in_fm.
        set_req(0, 32'h0004_0000, 16'd18);
        step();
        req_trans_start = '0;
        check("single_not_yet", 64'(rmst_trans_start), 64'd0);
        step();
        check("single_pulse_len", 64'(rmst_trans_start), 64'd1);
        step();
        check("single_busy", 64'(rmst_busy), 64'd1);
        step();
        step();
        step();
        rmst_trans_done = 1'b1;
        step();
        rmst_trans_done = 1'b0;
        check("single_rdone", 64'(req_trans_done), 64'b001);
        check("single_busy_drop", 64'(rmst_busy), 64'd0);
        step();
        check("single_rdone_low", 64'(req_trans_done), 64'd0);
        check("single_idle", 64'(rmst_trans_start), 64'd0);

        // Reset so rr_ptr is 0, then all three start together twice.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 32'h1000, 16'd4);
        set_req(1, 32'h2000, 16'd8);
        set_req(2, 32'h3000, 16'd12);
        step();
        req_trans_start = '0;
        step();
        serve("rr1_g0", 0, 32'h1000, 16'd4);
        step();
        serve("rr1_g1", 1, 32'h2000, 16'd8);
        step();
        serve("rr1_g2", 2, 32'h3000, 16'd12);
        set_req(0, 32'h1100, 16'd5);
        set_req(1, 32'h2200, 16'd9);
        set_req(2, 32'h3300, 16'd13);
        step();
        req_trans_start = '0;
        step();
        serve("rr2_g0", 0, 32'h1100, 16'd5);
        step();
        serve("rr2_g1", 1, 32'h2200, 16'd9);
        step();
        serve("rr2_g2", 2, 32'h3300, 16'd13);

        // Fairness: requester 0 re-requests right after each done.
        set_req(0, 32'hA000, 16'd1);
        set_req(1, 32'hB000, 16'd2);
        step();
        req_trans_start = '0;
        step();
        serve("fair_g0a", 0, 32'hA000, 16'd1);
        set_req(0, 32'hA100, 16'd3);
        step();
        req_trans_start = '0;
        serve("fair_g1a", 1, 32'hB000, 16'd2);
        set_req(1, 32'hB100, 16'd4);
        step();
        req_trans_start = '0;
        serve("fair_g0b", 0, 32'hA100, 16'd3);
        set_req(0, 32'hA200, 16'd6);
        step();
        req_trans_start = '0;
        serve("fair_g1b", 1, 32'hB100, 16'd4);
        step();
        serve("fair_g0c", 0, 32'hA200, 16'd6);

        // Protocol error: weight starts twice.
        check("err_clear", 64'(proto_err), 64'd0);
        set_req(1, 32'hC000, 16'd7);
        step();
        set_req(1, 32'hD000, 16'd9);
        step();
        req_trans_start = '0;
        check("err_set", 64'(proto_err), 64'd1);
        serve("err_g1", 1, 32'hC000, 16'd7);
        step();
        check("err_no_second_start", 64'(rmst_trans_start), 64'd0);
        check("err_no_second_busy", 64'(rmst_busy), 64'd0);
        step();
        check("err_still_idle", 64'(rmst_trans_start), 64'd0);
        check("err_sticky", 64'(proto_err), 64'd1);

        // Stray done in IDLE.
        rmst_trans_done = 1'b1;
        step();
        rmst_trans_done = 1'b0;
        check("stray_rdone", 64'(req_trans_done), 64'd0);
        check("stray_busy", 64'(rmst_busy), 64'd0);
        check("stray_grant_hold", 64'(rmst_grant_id), 64'd1);
        step();
        check("stray_no_start", 64'(rmst_trans_start), 64'd0);

        // Done for 0 coincides with a new start from 2.
        set_req(0, 32'hE000, 16'd10);
        step();
        req_trans_start = '0;
        step();
        check("coinc_start", 64'(rmst_trans_start), 64'd1);
        check("coinc_grant", 64'(rmst_grant_id), 64'd0);
        step();
        step();
        rmst_trans_done = 1'b1;
        set_req(2, 32'hF000, 16'd11);
        step();
        rmst_trans_done = 1'b0;
        req_trans_start = '0;
        check("coinc_rdone", 64'(req_trans_done), 64'b001);
        step();
        serve("coinc_g2", 2, 32'hF000, 16'd11);

        // Reset in the middle of a burst for requester 1.
        set_req(0, 32'h5000, 16'd3);
        step();
        req_trans_start = '0;
        step();
        serve("pre_rst_g0", 0, 32'h5000, 16'd3);
        step();
        set_req(1, 32'h6000, 16'd5);
        step();
        req_trans_start = '0;
        step();
        check("pre_rst_issue", 64'(rmst_grant_id), 64'd1);
        step();
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        rst = 1'b0;
        check_all_zero("rst_release");
        rmst_trans_done = 1'b1;
        step();
        rmst_trans_done = 1'b0;
        check("late_done_rdone", 64'(req_trans_done), 64'd0);
        check("late_done_busy", 64'(rmst_busy), 64'd0);
        set_req(0, 32'h7000, 16'd0);
        set_req(2, 32'h8000, 16'd2);
        step();
        req_trans_start = '0;
        step();
        serve("post_rst_g0", 0, 32'h7000, 16'd0);
        step();
        serve("post_rst_g2", 2, 32'h8000, 16'd2);
        check("post_rst_err", 64'(proto_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rmst_arbiter.md
Name: rmst_arbiter

Overview:
- Shares the single Avalon read master between three load controllers: input FM, weight and output-FM partial-sum reload.
- Each controller issues row-burst transactions as a one-cycle start pulse with address and length.
- The arbiter queues one request per requester, grants round-robin, and issues exactly one burst to the read master at a time.
- It returns a per-requester done pulse and a grant id that steers read data to the owning FIFO.

Parameters:
- XAW, 32, external byte-address width
- CW, 16, burst-length and counter width
- NREQ, 3, number of requesters; fixed at 3, other values unsupported

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_trans_start  in  3  per-requester start pulse: bit0 in_fm, bit1 weight, bit2 out_fm
- req_raddr  in  3*XAW  per-requester byte address; slice i = [i*XAW +: XAW]; sampled only with its start bit
- req_iolen  in  3*CW  per-requester burst length in words; sampled only with its start bit
- req_trans_done  out  3  per-requester one-cycle completion pulse
- rmst_trans_start  out  1  one-cycle start to the read master
- rmst_raddr  out  XAW  address to the read master, held from issue until the next issue
- rmst_iolen  out  CW  length to the read master, held likewise
- rmst_trans_done  in  1  one-cycle completion from the read master
- rmst_grant_id  out  2  owner of the current or last burst (0..2)
- rmst_busy  out  1  high from issue through completion
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst=1): every output is 0, including req_trans_done, rmst_trans_start, rmst_raddr, rmst_iolen, rmst_grant_id, rmst_busy and proto_err.
  - pending[2:0]=0, rr_ptr=0, state=IDLE.
  - Reset mid-burst discards the burst. A rmst_trans_done arriving after reset release is ignored (state IDLE).
- Request capture: on the edge where req_trans_start[i]=1 and pending[i]=0:
  - pending[i] is set.
  - req_raddr[i] and req_iolen[i] are latched into slot i.
- Protocol error: req_trans_start[i]=1 while pending[i]=1 (includes i currently granted).
  - The new request is dropped; slot i is unchanged.
  - proto_err is set and stays set until reset.
- State machine:
  - IDLE: if any pending bit is set, pick the first pending index scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3), call it g; go to ISSUE. At that edge rmst_raddr/rmst_iolen are loaded from slot g and rmst_grant_id<=g.
  - ISSUE (one cycle): rmst_trans_start=1 and rmst_busy=1; go to BUSY.
  - BUSY: rmst_busy=1. When rmst_trans_done=1: req_trans_done[g] pulses the next cycle, pending[g] clears, rr_ptr<=(g+1) mod 3, go to IDLE.
- Outputs are registered; rmst_trans_start is high only in ISSUE.
- Latency:
  - Start pulse sampled at edge t in IDLE with nothing pending: pending at t, state ISSUE after edge t+1, rmst_trans_start high in cycle t+1..t+2.
  - rmst_trans_done sampled at edge d: req_trans_done[g] high in cycle d..d+1.
  - Back-to-back issue: next rmst_trans_start begins one cycle after the done pulse (IDLE→ISSUE).
- Simultaneous events:
  - Several start bits on the same edge are all captured.
  - A capture on the same edge as completion of another requester is kept.
  - A new start from requester g is legal from the edge after its req_trans_done pulse. On the completion edge pending[g] is still 1, so a start there is an error.
- rmst_trans_done while IDLE or ISSUE: ignored, no error.
- rmst_grant_id holds its last value in IDLE.
- iolen=0 is passed through unchanged; the arbiter does not check it.

Test Plan:
- Single request: in_fm start with raddr=0x40000, iolen=18 → one rmst_trans_start pulse with rmst_raddr=0x40000, rmst_iolen=18, grant_id=0; done returned 5 cycles later → req_trans_done=3'b001 one cycle later, rmst_busy drops.
- All three start on the same edge, rr_ptr=0 → issue order 0,1,2, each after the prior done; next round (all three again) also 0,1,2 since rr_ptr wraps to 0.
- Fairness: requester 0 re-requests immediately after every done while 1 is pending → grants alternate 0,1,0,1; requester 1 never waits more than one burst.
- Protocol error: weight start twice without an intervening done → proto_err=1, second address ignored, only one burst issued for requester 1.
- Stray done: rmst_trans_done pulsed in IDLE → no req_trans_done and no state change. Done and a new req_trans_start[2] on the same edge while granting 0 → done to 0, then requester 2 issued next.
- Reset mid-BUSY: rst asserted during a burst → all outputs 0 immediately; after release a late rmst_trans_done gives no done pulse, and a new request issues normally with grant_id per rr_ptr=0.
